// File: rtl/sr_gen_pkg.sv
// Shared types and constants for the debounced SR strobe generator.
// Debounce FSM state encoding plus default and simulation debounce lengths.
package sr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM_HI = 2'b01,
    HELD   = 2'b10,
    ARM_LO = 2'b11
  } db_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
  localparam int unsigned CNT_W_DEF           = 16;

  // The debounced level is high in HELD and while a release is still being qualified.
  function automatic logic level_of(input db_state_e s);
    return (s == HELD) || (s == ARM_LO);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Per-button conditioner: 2-FF synchronizer, debounce FSM, saturating counter.
// Latency: ev is presented one cycle before the debounced level register would change.
// No backpressure; a raw level must hold DEBOUNCE_CYCLES+1 synced samples to be accepted.
module sr_debounce
  import sr_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter bit          LEVEL_MODE      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic ev
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  db_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       lvl_nxt;
  logic       rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Taken from the next state so the top's output flop lands in the same cycle the FSM commits.
  always_comb begin
    lvl_nxt = level_of(state_d);
    rise    = lvl_nxt & ~level_of(state_q);
    ev      = LEVEL_MODE ? lvl_nxt : rise;
  end

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced set/reset strobe generator feeding a NOR SR latch; reset wins on a tie.
// Latency: 2 sync + DEBOUNCE_CYCLES count + 1 output register cycles from a stable edge.
// No backpressure; `define SR_PULSE_GEN_LEVEL_EN selects level outputs instead of pulses.
module sr_pulse_gen
  import sr_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic conflict
);

`ifdef SR_PULSE_GEN_LEVEL_EN
  localparam bit LEVEL_MODE = 1'b1;
`else
  localparam bit LEVEL_MODE = 1'b0;
`endif

  logic set_ev;
  logic rst_ev;
  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .LEVEL_MODE      (LEVEL_MODE)
  ) u_db_set (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_set),
    .ev      (set_ev)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .LEVEL_MODE      (LEVEL_MODE)
  ) u_db_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_rst),
    .ev      (rst_ev)
  );

  // The same arbitration covers both modes: ev is a rise in pulse mode and a level otherwise.
  always_comb begin
    s_d        = set_ev & ~rst_ev;
    r_d        = rst_ev;
    conflict_d = set_ev & rst_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Self-checking bench for sr_pulse_gen with DEBOUNCE_CYCLES=4 against a run-length reference model.
module tb_sr_pulse_gen;

  localparam int unsigned DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic S, R, conflict;

  int n_chk = 0;
  int n_pass = 0;

  sr_pulse_gen #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .S        (S),
    .R        (R),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // Reference: a button's accepted level flips once DC+1 consecutive synchronized
  // samples disagree with it; samples reach the debouncer two clocks after the pins.
  logic [1:0] m_p1, m_p2, m_deb;
  int         m_run [2];
  logic       e_S, e_R, e_C;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 <= 2'b00; m_p2 <= 2'b00; m_deb <= 2'b00;
      m_run[0] <= 0; m_run[1] <= 0;
      e_S <= 1'b0; e_R <= 1'b0; e_C <= 1'b0;
    end else begin : model_step
      automatic logic [1:0] deb_n = m_deb;
      automatic logic [1:0] rise_n = 2'b00;
      for (int c = 0; c < 2; c++) begin
        automatic int run_n = (m_p2[c] != m_deb[c]) ? m_run[c] + 1 : 0;
        if (run_n == DC + 1) begin
          deb_n[c]  = ~m_deb[c];
          rise_n[c] = deb_n[c];
          run_n     = 0;
        end
        m_run[c] <= run_n;
      end
      m_p1  <= {btn_rst, btn_set};
      m_p2  <= m_p1;
      m_deb <= deb_n;
`ifdef SR_PULSE_GEN_LEVEL_EN
      e_S <= deb_n[0] & ~deb_n[1];
      e_R <= deb_n[1];
      e_C <= deb_n[0] & deb_n[1];
`else
      e_S <= rise_n[0] & ~rise_n[1];
      e_R <= rise_n[1];
      e_C <= rise_n[0] & rise_n[1];
`endif
    end
  end

  task automatic settle();
    btn_set = 1'b0;
    btn_rst = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    int s_cnt = 0, s_at = -1, rc_cnt = 0;
    btn_set = 1'b1;
    btn_rst = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({S, R, conflict} !== 3'b000) $display("FAIL reset_hold: SRC=%b%b%b want 000", S, R, conflict);
    else n_pass++;
    btn_rst = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C})
        $display("FAIL reset_release cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) begin s_cnt++; if (s_at < 0) s_at = i; end
      if (R || conflict) rc_cnt++;
    end
`ifndef SR_PULSE_GEN_LEVEL_EN
    n_chk++;
    if (s_cnt !== 1 || s_at !== 7 || rc_cnt !== 0)
      $display("FAIL reset_release_pulse: count=%0d at=%0d rc=%0d want 1 at 7 rc 0", s_cnt, s_at, rc_cnt);
    else n_pass++;
`endif
    settle();
  endtask

  task automatic test_clean_press();
    int s_cnt = 0, s_at = -1, r_cnt = 0;
    btn_set = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C})
        $display("FAIL clean_press cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) begin s_cnt++; if (s_at < 0) s_at = i; end
      if (R) r_cnt++;
      if (i == 20) btn_set = 1'b0;
    end
    n_chk++;
`ifdef SR_PULSE_GEN_LEVEL_EN
    if (s_cnt !== 20 || s_at !== 7 || r_cnt !== 0)
      $display("FAIL clean_press_level: high=%0d at=%0d r=%0d want 20 at 7 r 0", s_cnt, s_at, r_cnt);
    else n_pass++;
`else
    if (s_cnt !== 1 || s_at !== 7 || r_cnt !== 0)
      $display("FAIL clean_press_pulse: count=%0d at=%0d r=%0d want 1 at 7 r 0", s_cnt, s_at, r_cnt);
    else n_pass++;
`endif
    settle();
  endtask

  task automatic test_bounce();
    int s_cnt = 0, s_at = -1;
    for (int i = 0; i < 12; i++) begin
      btn_set = ((i / 2) % 2 == 0);
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C} || S !== 1'b0)
        $display("FAIL bounce cyc%0d: SRC=%b%b%b want %b%b%b and S=0", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
    end
    btn_set = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C})
        $display("FAIL bounce_settle cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) begin s_cnt++; if (s_at < 0) s_at = i; end
    end
`ifndef SR_PULSE_GEN_LEVEL_EN
    n_chk++;
    if (s_cnt !== 1 || s_at !== 7)
      $display("FAIL bounce_settle_pulse: count=%0d at=%0d want 1 at 7", s_cnt, s_at);
    else n_pass++;
`endif
    settle();
  endtask

  task automatic test_simultaneous();
    int s_cnt = 0, r_at = -1, c_at = -1;
    btn_set = 1'b1;
    btn_rst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C})
        $display("FAIL simultaneous cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) s_cnt++;
      if (R && r_at < 0) r_at = i;
      if (conflict && c_at < 0) c_at = i;
    end
    n_chk++;
    if (s_cnt !== 0 || r_at !== 7 || c_at !== 7)
      $display("FAIL simultaneous_arb: S=%0d R_at=%0d conflict_at=%0d want 0, 7, 7", s_cnt, r_at, c_at);
    else n_pass++;
    settle();
  endtask

  task automatic test_back_to_back();
    int s_cnt = 0, r_cnt = 0, c_cnt = 0, s_at = -1, r_at = -1;
    btn_rst = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C} || (S & R) !== 1'b0)
        $display("FAIL held_overlap cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) begin s_cnt++; if (s_at < 0) s_at = i; end
      if (R) begin r_cnt++; if (r_at < 0) r_at = i; end
      if (conflict) c_cnt++;
      if (i == 10) btn_set = 1'b1;
    end
`ifndef SR_PULSE_GEN_LEVEL_EN
    n_chk++;
    if (r_cnt !== 1 || r_at !== 7 || s_cnt !== 1 || s_at !== 17 || c_cnt !== 0)
      $display("FAIL held_overlap_seq: R %0d@%0d S %0d@%0d conflict %0d want R 1@7 S 1@17 conflict 0",
               r_cnt, r_at, s_cnt, s_at, c_cnt);
    else n_pass++;
`endif
    settle();
  endtask

  task automatic test_async_reset();
    int s_cnt = 0;
    // Reset while the strobe is high must clear it without waiting for a clock.
    btn_set = 1'b1;
    repeat (7) @(negedge clk);
    n_chk++;
    if (S !== e_S) $display("FAIL async_prepulse: S=%b want %b", S, e_S);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({S, R, conflict} !== 3'b000) $display("FAIL async_midpulse: SRC=%b%b%b want 000", S, R, conflict);
    else n_pass++;
    btn_set = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // Now two cycles into qualifying a fresh press.
    btn_set = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({S, R, conflict} !== 3'b000) $display("FAIL async_midcount: SRC=%b%b%b want 000", S, R, conflict);
    else n_pass++;
    btn_set = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C})
        $display("FAIL async_after cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
      if (S) s_cnt++;
    end
    n_chk++;
    if (s_cnt !== 0) $display("FAIL async_no_strobe: S count=%0d want 0", s_cnt);
    else n_pass++;
    settle();
  endtask

  task automatic test_random();
    int hs = 0, hr = 0;
    for (int i = 0; i < 600; i++) begin
      if (hs == 0) begin btn_set = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
      if (hr == 0) begin btn_rst = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 12); end
      hs--;
      hr--;
      @(negedge clk);
      n_chk++;
      if ({S, R, conflict} !== {e_S, e_R, e_C} || (S & R) !== 1'b0)
        $display("FAIL random cyc%0d: SRC=%b%b%b want %b%b%b", i, S, R, conflict, e_S, e_R, e_C);
      else n_pass++;
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
